// File: rtl/mod_updown_counter_pkg.sv
// Shared counter definitions: state encoding and terminal-value helper
// used by the up/down counter and other timer blocks.
package counter_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    // One extra bit so a modulus of exactly 2^MAX_WIDTH can be expressed.
    typedef logic [MAX_WIDTH:0] modulus_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cnt_state_t;

    // Largest count value for a given width and modulus. Modulus 0 means the
    // full binary range. A modulus of 2^width yields all ones as well.
    function automatic logic [MAX_WIDTH-1:0] calc_max(input int unsigned width,
                                                      input modulus_t    modulus);
        logic [MAX_WIDTH-1:0] ones;
        ones = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        if (modulus == '0) begin
            return ones;
        end
        return (modulus[MAX_WIDTH-1:0] - 64'd1) & ones;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the up/down counter. The master side drives the
// controls and observes the count; the slave side is the counter itself.
interface mod_updown_counter_if #(
    parameter int unsigned WIDTH = 64
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             dir;
    logic             one_shot;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             running;
    logic             done;

    modport master (
        output clr, load, load_val, start, stop, dir, one_shot,
        input  q, tc, running, done
    );

    modport slave (
        input  clr, load, load_val, start, stop, dir, one_shot,
        output q, tc, running, done
    );
endinterface

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Clock prescaler: while enabled, asserts tick on every PRESCALE-th cycle.
// tick is combinational from the registered phase counter so the parent can
// act on it at the same edge the phase counter wraps.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick = en && (pre_cnt == LAST);

    // Phase counter: cleared on request, advances and wraps only while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (sync_clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with programmable modulus, prescaler,
// parallel load and one-shot mode. All outputs are registered.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter modulus_t    MODULUS  = '0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(calc_max(WIDTH, MODULUS));

    cnt_state_t       state;
    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             running_r;
    logic             done_r;
    logic             mode_one_shot;
    logic             tick;
    logic             pre_clr;

    // The prescaler phase restarts on any control action that re-times counting;
    // start while already running is ignored and must not disturb the phase.
    assign pre_clr = bus.clr || bus.load || bus.stop || (bus.start && (state != RUN));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (state == RUN),
        .sync_clr (pre_clr),
        .tick     (tick)
    );

    // State machine, mode register and count/terminal-count registers,
    // with control priority clr > load > stop > start > count step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            q_r           <= '0;
            tc_r          <= 1'b0;
            running_r     <= 1'b0;
            done_r        <= 1'b0;
            mode_one_shot <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (bus.clr) begin
                q_r       <= '0;
                state     <= IDLE;
                running_r <= 1'b0;
                done_r    <= 1'b0;
            end else if (bus.load) begin
                q_r <= (bus.load_val > MAX) ? MAX : bus.load_val;
                if (state == DONE) begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
            end else if (bus.stop) begin
                state     <= IDLE;
                running_r <= 1'b0;
                done_r    <= 1'b0;
            end else if (bus.start && (state != RUN)) begin
                state         <= RUN;
                running_r     <= 1'b1;
                done_r        <= 1'b0;
                mode_one_shot <= bus.one_shot;
            end else if ((state == RUN) && tick) begin
                if (bus.dir) begin
                    if (q_r < MAX) begin
                        q_r <= q_r + 1'b1;
                    end else begin
                        tc_r <= 1'b1;
                        if (mode_one_shot) begin
                            state     <= DONE;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            q_r <= '0;
                        end
                    end
                end else begin
                    if (q_r != '0) begin
                        q_r <= q_r - 1'b1;
                    end else begin
                        tc_r <= 1'b1;
                        if (mode_one_shot) begin
                            state     <= DONE;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            q_r <= MAX;
                        end
                    end
                end
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.tc      = tc_r;
    assign bus.running = running_r;
    assign bus.done    = done_r;
endmodule
